mult_div_unit: RTL

//  Iterative 32-bit signed multiply/divide engine that executes MULT, DIV and MUL.
//  It sits beside the ALU and directly downstream of the sequence controller.
//  It is started by the controller's mult_start/div_start, and answers with a one-cycle mult_div_done.
//  hi_out/lo_out feed the HI/LO registers (hi_SEL=1/lo_SEL=1 path) and the ALU result mux (MUL).

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit signed multiply/divide engine
// Optional MD_UNSIGNED_EN adds is_unsigned for MULTU/DIVU operation.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mult_start,
  input  logic             div_start,
`ifdef MD_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_div_done,
  output logic             busy,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   low, opm;
  logic [CNT_W-1:0]   cnt;
  logic               sign_a, sign_b, is_div, dz;

  logic               start, start_div, uns, neg_a, neg_b, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mult_sum, div_rem;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign start     = mult_start | div_start;
  assign start_div = div_start & ~mult_start;
  assign b_zero    = (operand_b == '0);
`ifdef MD_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Unsigned mode forces the signs to 0, so magnitude and sign fix become no-ops.
  assign neg_a = operand_a[WIDTH-1] & ~uns;
  assign neg_b = operand_b[WIDTH-1] & ~uns;
  assign abs_a = neg_a ? -operand_a : operand_a;
  assign abs_b = neg_b ? -operand_b : operand_b;

  // acc holds the multiply upper half (with carry) or the division remainder.
  assign mult_sum = acc + {1'b0, (low[0] ? opm : {WIDTH{1'b0}})};
  assign div_rem  = {acc[WIDTH-1:0], low[WIDTH-1]};
  assign div_diff = {1'b0, div_rem} - {2'b00, opm};

  assign prod     = {acc[WIDTH-1:0], low};
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  assign quot_fix = (sign_a ^ sign_b) ? -low : low;
  assign rem_fix  = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (start_div && b_zero) ? FIX : RUN;
      RUN:  if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc <= '0; low <= '0; opm <= '0; cnt <= '0;
      sign_a <= 1'b0; sign_b <= 1'b0; is_div <= 1'b0; dz <= 1'b0;
      hi_out <= '0; lo_out <= '0;
      mult_div_done <= 1'b0; busy <= 1'b0; div_zero <= 1'b0;
    end else begin
      mult_div_done <= 1'b0;
      div_zero      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_div <= start_div;
          sign_a <= neg_a;
          sign_b <= neg_b;
          dz     <= start_div && b_zero;
          acc    <= '0;
          cnt    <= CNT_W'(WIDTH);
          busy   <= 1'b1;
          if (start_div) begin
            // Divide by zero keeps the raw dividend so it can be returned in hi.
            low <= b_zero ? operand_a : abs_a;
            opm <= abs_b;
          end else begin
            low <= abs_b;
            opm <= abs_a;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc <= div_diff[WIDTH+1] ? div_rem : div_diff[WIDTH:0];
            low <= {low[WIDTH-2:0], ~div_diff[WIDTH+1]};
          end else begin
            {acc, low} <= {mult_sum, low} >> 1;
          end
        end
        FIX: begin
          busy          <= 1'b0;
          mult_div_done <= 1'b1;
          if (dz) begin
            hi_out   <= low;
            lo_out   <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
          end else begin
            {hi_out, lo_out} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
